doraemon_select_engine: RTL and testbench



---
 rtl/doraemon_select_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_doraemon_select_engine.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doraemon_select_engine.sv
// doraemon_select_engine
// Candidate-selection engine in the clk1 domain. Holds SLOTS candidate
// records; every post-fill beat scores all stored slots against the beat's
// weights, emits {winning slot index, winning slot ID} on a valid/ready
// stream, then replaces the winning slot with the incoming candidate.
// The output stream is meant to feed the write side of an async FIFO
// (out_ready = !wfull) towards the clk2 domain.
//
// Optional build macro: SELECT_SCORE_OUT_EN
//   defined   -> adds out_score, the winning score, registered with out_data
//   undefined -> scores are used only for the internal argmax
//
// state | meaning
// FILL  | loading slots 0..SLOTS-1 in order, weights ignored
// IDLE  | all slots loaded, waiting for a post-fill beat
// CALC  | registering the score of every slot
// PICK  | registering the argmax (lowest index wins ties) into the output
// EMIT  | result presented, waiting for out_ready, then winner replaced
module doraemon_select_engine #(
  parameter  int SLOTS = 5,
  parameter  int DW    = 8,
  parameter  int WW    = 3,
  parameter  int IDW   = 5,
  localparam int SELW  = $clog2(SLOTS),
  localparam int PW    = DW + WW + 2
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDW-1:0]       in_id,
  input  logic [DW-1:0]        in_size,
  input  logic [DW-1:0]        in_iq,
  input  logic [DW-1:0]        in_eq,
  input  logic [WW-1:0]        w_size,
  input  logic [WW-1:0]        w_iq,
  input  logic [WW-1:0]        w_eq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW+IDW-1:0]  out_data,
  output logic                 fill_done
`ifdef SELECT_SCORE_OUT_EN
  ,
  output logic [PW-1:0]        out_score
`endif
);

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_IDLE = 3'd1,
    S_CALC = 3'd2,
    S_PICK = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDW-1:0]  slot_id   [SLOTS];
  logic [DW-1:0]   slot_size [SLOTS];
  logic [DW-1:0]   slot_iq   [SLOTS];
  logic [DW-1:0]   slot_eq   [SLOTS];
  logic [PW-1:0]   score     [SLOTS];

  logic [IDW-1:0]  pend_id;
  logic [DW-1:0]   pend_size;
  logic [DW-1:0]   pend_iq;
  logic [DW-1:0]   pend_eq;
  logic [WW-1:0]   wt_size;
  logic [WW-1:0]   wt_iq;
  logic [WW-1:0]   wt_eq;

  logic [SELW-1:0] fill_cnt;
  logic [SELW-1:0] win_idx;
  logic [SELW-1:0] pick_idx;
  logic [IDW-1:0]  pick_id;
  logic [PW-1:0]   pick_score;

  logic            accept;
  logic            fill_last;
  logic            replace;

  assign accept    = in_valid & in_ready;
  assign fill_last = (fill_cnt == SELW'(SLOTS - 1));
  assign replace   = (state == S_EMIT) & out_ready;

  // Weighted score of one slot; operands widened first so nothing overflows.
  function automatic logic [PW-1:0] slot_score(
    input logic [DW-1:0] s,
    input logic [DW-1:0] q,
    input logic [DW-1:0] e,
    input logic [WW-1:0] ws,
    input logic [WW-1:0] wq,
    input logic [WW-1:0] we
  );
    return (PW'(s) * PW'(ws)) + (PW'(q) * PW'(wq)) + (PW'(e) * PW'(we));
  endfunction

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_FILL;
    end else begin
      unique case (state)
        S_FILL:  if (accept && fill_last) state_nxt = S_IDLE;
        S_IDLE:  if (accept)              state_nxt = S_CALC;
        S_CALC:                           state_nxt = S_PICK;
        S_PICK:                           state_nxt = S_EMIT;
        S_EMIT:  if (out_ready)           state_nxt = S_IDLE;
        default:                          state_nxt = S_FILL;
      endcase
    end
  end

  // Output decode: beats are only taken while loading or idle.
  always_comb begin
    in_ready = 1'b0;
    if (!clear && (state == S_FILL || state == S_IDLE)) begin
      in_ready = 1'b1;
    end
  end

  // Slot storage: sequential fill, then replacement of the emitted winner.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_id[i]   <= '0;
        slot_size[i] <= '0;
        slot_iq[i]   <= '0;
        slot_eq[i]   <= '0;
      end
      fill_cnt  <= '0;
      fill_done <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_id[i]   <= '0;
        slot_size[i] <= '0;
        slot_iq[i]   <= '0;
        slot_eq[i]   <= '0;
      end
      fill_cnt  <= '0;
      fill_done <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (state == S_FILL && accept && fill_cnt == SELW'(i)) begin
          slot_id[i]   <= in_id;
          slot_size[i] <= in_size;
          slot_iq[i]   <= in_iq;
          slot_eq[i]   <= in_eq;
        end else if (replace && win_idx == SELW'(i)) begin
          slot_id[i]   <= pend_id;
          slot_size[i] <= pend_size;
          slot_iq[i]   <= pend_iq;
          slot_eq[i]   <= pend_eq;
        end
      end
      if (state == S_FILL && accept) begin
        fill_cnt <= fill_cnt + SELW'(1);
        if (fill_last) begin
          fill_done <= 1'b1;
        end
      end
    end
  end

  // Pending candidate and weights captured from the post-fill beat.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pend_id   <= '0;
      pend_size <= '0;
      pend_iq   <= '0;
      pend_eq   <= '0;
      wt_size   <= '0;
      wt_iq     <= '0;
      wt_eq     <= '0;
    end else if (clear) begin
      pend_id   <= '0;
      pend_size <= '0;
      pend_iq   <= '0;
      pend_eq   <= '0;
      wt_size   <= '0;
      wt_iq     <= '0;
      wt_eq     <= '0;
    end else if (state == S_IDLE && accept) begin
      pend_id   <= in_id;
      pend_size <= in_size;
      pend_iq   <= in_iq;
      pend_eq   <= in_eq;
      wt_size   <= w_size;
      wt_iq     <= w_iq;
      wt_eq     <= w_eq;
    end
  end

  // Score registers, loaded for every slot in the CALC cycle.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        score[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < SLOTS; i++) begin
        score[i] <= '0;
      end
    end else if (state == S_CALC) begin
      for (int i = 0; i < SLOTS; i++) begin
        score[i] <= slot_score(slot_size[i], slot_iq[i], slot_eq[i],
                               wt_size, wt_iq, wt_eq);
      end
    end
  end

  // Argmax over the registered scores; strict compare keeps the lowest index on ties.
  always_comb begin
    pick_idx   = '0;
    pick_id    = slot_id[0];
    pick_score = score[0];
    for (int i = 1; i < SLOTS; i++) begin
      if (score[i] > pick_score) begin
        pick_idx   = SELW'(i);
        pick_id    = slot_id[i];
        pick_score = score[i];
      end
    end
  end

  // Result registers: loaded in PICK, held through EMIT until the handshake.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      win_idx   <= '0;
`ifdef SELECT_SCORE_OUT_EN
      out_score <= '0;
`endif
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      win_idx   <= '0;
`ifdef SELECT_SCORE_OUT_EN
      out_score <= '0;
`endif
    end else if (state == S_PICK) begin
      out_valid <= 1'b1;
      out_data  <= {pick_idx, pick_id};
      win_idx   <= pick_idx;
`ifdef SELECT_SCORE_OUT_EN
      out_score <= pick_score;
`endif
    end else if (replace) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_doraemon_select_engine.sv
// Directed bench for doraemon_select_engine: default instance (SLOTS=5, DW=8)
// plus a SLOTS=8, DW=10 instance checked against a small argmax model.
module tb_doraemon_select_engine;

  logic        clk1;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_id;
  logic [7:0]  in_size;
  logic [7:0]  in_iq;
  logic [7:0]  in_eq;
  logic [2:0]  w_size;
  logic [2:0]  w_iq;
  logic [2:0]  w_eq;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        fill_done;
`ifdef SELECT_SCORE_OUT_EN
  logic [12:0] out_score;
  logic [14:0] b_out_score;
`endif

  logic        b_clear;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_in_id;
  logic [9:0]  b_in_size;
  logic [9:0]  b_in_iq;
  logic [9:0]  b_in_eq;
  logic [2:0]  b_w_size;
  logic [2:0]  b_w_iq;
  logic [2:0]  b_w_eq;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_data;
  logic        b_fill_done;

  int checks = 0;
  int errors = 0;

  int m_id   [8];
  int m_size [8];
  int m_iq   [8];
  int m_eq   [8];

  doraemon_select_engine dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_size   (in_size),
    .in_iq     (in_iq),
    .in_eq     (in_eq),
    .w_size    (w_size),
    .w_iq      (w_iq),
    .w_eq      (w_eq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill_done (fill_done)
`ifdef SELECT_SCORE_OUT_EN
    ,
    .out_score (out_score)
`endif
  );

  doraemon_select_engine #(.SLOTS(8), .DW(10), .WW(3), .IDW(5)) dut_b (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .clear     (b_clear),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_id     (b_in_id),
    .in_size   (b_in_size),
    .in_iq     (b_in_iq),
    .in_eq     (b_in_eq),
    .w_size    (b_w_size),
    .w_iq      (b_w_iq),
    .w_eq      (b_w_eq),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .fill_done (b_fill_done)
`ifdef SELECT_SCORE_OUT_EN
    ,
    .out_score (b_out_score)
`endif
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Present one beat on the default instance; waits (bounded) for in_ready.
  task automatic beat(input logic [4:0] id, input logic [7:0] s, input logic [7:0] q,
                      input logic [7:0] e, input logic [2:0] ws, input logic [2:0] wq,
                      input logic [2:0] we);
    int n;
    n = 0;
    @(negedge clk1);
    while (!in_ready && n < 20) begin
      @(negedge clk1);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready_timeout: in_ready=%b expected 1", in_ready);
    end
    in_id = id; in_size = s; in_iq = q; in_eq = e;
    w_size = ws; w_iq = wq; w_eq = we;
    in_valid = 1'b1;
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
  endtask

  // Present one beat on the SLOTS=8 instance; waits (bounded) for in_ready.
  task automatic b_beat(input int id, input int s, input int q, input int e,
                        input int ws, input int wq, input int we);
    int n;
    n = 0;
    @(negedge clk1);
    while (!b_in_ready && n < 20) begin
      @(negedge clk1);
      n++;
    end
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_beat_ready_timeout: in_ready=%b expected 1", b_in_ready);
    end
    b_in_id = 5'(id); b_in_size = 10'(s); b_in_iq = 10'(q); b_in_eq = 10'(e);
    b_w_size = 3'(ws); b_w_iq = 3'(wq); b_w_eq = 3'(we);
    b_in_valid = 1'b1;
    @(posedge clk1);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_id = '0; in_size = '0; in_iq = '0; in_eq = '0;
    w_size = '0; w_iq = '0; w_eq = '0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_id = '0; b_in_size = '0; b_in_iq = '0; b_in_eq = '0;
    b_w_size = '0; b_w_iq = '0; b_w_eq = '0;
    #22;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++;
    if (fill_done !== 1'b0) begin errors++; $display("FAIL reset_fill_done: got %b expected 0", fill_done); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (b_out_valid !== 1'b0 || b_fill_done !== 1'b0) begin
      errors++; $display("FAIL reset_b: out_valid=%b fill_done=%b expected 0 0", b_out_valid, b_fill_done);
    end
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    logic [7:0] sizes [5];
    sizes = '{8'd10, 8'd50, 8'd50, 8'd20, 8'd5};
    for (int i = 0; i < 5; i++) begin
      beat(5'(i + 1), sizes[i], 8'(i + 1), 8'd0, 3'd7, 3'd7, 3'd7);
      checks++;
      if (fill_done !== (i == 4)) begin
        errors++; $display("FAIL fill_done_beat%0d: got %b expected %b", i, fill_done, (i == 4));
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_output%0d: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_select_basic;
    beat(5'd9, 8'd3, 8'd200, 8'd0, 3'd1, 3'd0, 3'd0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_calc_valid: got %b expected 0", out_valid); end
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pick_valid: got %b expected 0", out_valid); end
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL basic_result: valid=%b data=%h expected 1 22", out_valid, out_data);
    end
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_handshake: valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_weights;
    beat(5'd10, 8'd100, 8'd0, 8'd0, 3'd0, 3'd0, 3'd0);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL zero_weights: valid=%b data=%h expected 1 01", out_valid, out_data);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_replaced_slot;
    beat(5'd11, 8'd7, 8'd7, 8'd7, 3'd0, 3'd1, 3'd0);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h29) begin
      errors++; $display("FAIL replaced_slot: valid=%b data=%h expected 1 29", out_valid, out_data);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_backpressure_tie;
    @(negedge clk1);
    clear = 1'b1;
    @(posedge clk1); #1;
    clear = 1'b0;
    checks++;
    if (fill_done !== 1'b0) begin errors++; $display("FAIL bp_clear_fill_done: got %b expected 0", fill_done); end
    for (int i = 0; i < 5; i++) begin
      beat(5'(i + 1), 8'd255, 8'd255, 8'd255, 3'd0, 3'd0, 3'd0);
    end
    out_ready = 1'b0;
    beat(5'd12, 8'd0, 8'd0, 8'd0, 3'd7, 3'd7, 3'd7);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL tie_result: valid=%b data=%h expected 1 01", out_valid, out_data);
    end
`ifdef SELECT_SCORE_OUT_EN
    checks++;
    if (out_score !== 13'd5355) begin errors++; $display("FAIL tie_score: got %0d expected 5355", out_score); end
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clk1); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b expected 1 01 0", i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk1);
    out_ready = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single: valid=%b expected 0", out_valid); end
    beat(5'd13, 8'd0, 8'd0, 8'd0, 3'd7, 3'd7, 3'd7);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL bp_after: valid=%b data=%h expected 1 22", out_valid, out_data);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_clear_in_pick;
    beat(5'd14, 8'd9, 8'd9, 8'd9, 3'd1, 3'd0, 3'd0);
    @(posedge clk1); #1;
    clear = 1'b1;
    in_id = 5'd30; in_size = 8'd200; in_iq = 8'd0; in_eq = 8'd0;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b expected 0", in_ready); end
    @(posedge clk1); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: valid=%b data=%h fill_done=%b expected 0 00 0", out_valid, out_data, fill_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk1); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_quiet%0d: valid=%b expected 0", i, out_valid); end
    end
    for (int i = 0; i < 5; i++) begin
      beat(5'(21 + i), 8'(i + 1), 8'd0, 8'd0, 3'd1, 3'd1, 3'd1);
      checks++;
      if (out_valid !== 1'b0 || fill_done !== (i == 4)) begin
        errors++;
        $display("FAIL refill%0d: valid=%b fill_done=%b expected 0 %b", i, out_valid, fill_done, (i == 4));
      end
    end
    beat(5'd26, 8'd0, 8'd0, 8'd0, 3'd1, 3'd0, 3'd0);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      errors++; $display("FAIL refill_result: valid=%b data=%h expected 1 99", out_valid, out_data);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_slots8;
    int sz [8]  = '{100, 900, 300, 1023, 50, 1023, 7, 0};
    int iq [8]  = '{5, 600, 20, 0, 1000, 0, 900, 1};
    int eq [8]  = '{0, 0, 800, 10, 3, 10, 2, 1023};
    int rid [3] = '{17, 18, 19};
    int rsz [3] = '{20, 500, 0};
    int riq [3] = '{30, 500, 0};
    int req [3] = '{40, 500, 0};
    int rws [3] = '{1, 2, 7};
    int rwq [3] = '{0, 3, 7};
    int rwe [3] = '{0, 1, 7};
    int best;
    int bidx;
    int sc;
    logic [7:0] expv;
    for (int i = 0; i < 8; i++) begin
      m_id[i] = i + 1; m_size[i] = sz[i]; m_iq[i] = iq[i]; m_eq[i] = eq[i];
      b_beat(i + 1, sz[i], iq[i], eq[i], 5, 5, 5);
    end
    checks++;
    if (b_fill_done !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL s8_fill: fill_done=%b valid=%b expected 1 0", b_fill_done, b_out_valid);
    end
    for (int r = 0; r < 3; r++) begin
      best = -1;
      bidx = 0;
      for (int i = 0; i < 8; i++) begin
        sc = m_size[i] * rws[r] + m_iq[i] * rwq[r] + m_eq[i] * rwe[r];
        if (sc > best) begin
          best = sc;
          bidx = i;
        end
      end
      expv = {3'(bidx), 5'(m_id[bidx])};
      b_beat(rid[r], rsz[r], riq[r], req[r], rws[r], rwq[r], rwe[r]);
      @(posedge clk1); #1;
      @(posedge clk1); #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== expv) begin
        errors++;
        $display("FAIL s8_round%0d: valid=%b data=%h expected 1 %h", r, b_out_valid, b_out_data, expv);
      end
      @(posedge clk1); #1;
      checks++;
      if (b_out_valid !== 1'b0) begin errors++; $display("FAIL s8_hs%0d: valid=%b expected 0", r, b_out_valid); end
      m_id[bidx] = rid[r]; m_size[bidx] = rsz[r]; m_iq[bidx] = riq[r]; m_eq[bidx] = req[r];
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_select_basic();
    test_zero_weights();
    test_replaced_slot();
    test_backpressure_tie();
    test_clear_in_pick();
    test_slots8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
